seven_segment_scan_controller: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display on the step-motor board. Owns the refresh prescaler and the digit sequencer, and drives active-low anode enables and segment lines. Display data arrives through a valid/ready update port into a double buffer. The active value only changes at a frame boundary, so no digit ever shows a mix of old and new values (no tearing).

---
 rtl/seven_segment_scan_controller.sv | 152 +++++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_controller.sv
// Four-digit common-anode seven-segment scan controller with a double-buffered update port.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seven_segment_scan_controller #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        displayOn,
    input  logic        updateValid,
    output logic        updateReady,
    input  logic [15:0] displayValue,
    output logic [3:0]  switchEnable,
    output logic [6:0]  segments,
    output logic        frameDone
);

    localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

    localparam logic [0:0] ST_OFF  = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [PRESC_W-1:0] prescaler;
    logic [1:0]         digit_idx;
    logic [0:0]         state;
    logic [0:0]         state_next;
    logic [15:0]        pending;
    logic               pending_full;
    logic [15:0]        active;
    logic               active_loaded;
    logic               tick;
    logic               boundary;
    logic               accept;
    logic               transfer;
    logic [3:0]         nibble;
    logic [6:0]         digit_seg;
    logic               digit_blank;
    logic [3:0]         switch_next;
    logic [6:0]         segments_next;

    assign tick        = (prescaler == PRESC_MAX);
    assign boundary    = tick && (digit_idx == 2'd3);
    assign updateReady = !pending_full && !reset;
    assign accept      = updateValid && updateReady;
    assign transfer    = boundary && pending_full;
    assign nibble      = active[{digit_idx, 2'b00} +: 4];

    // Refresh timing and the pending/active double buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler     <= '0;
            digit_idx     <= 2'd0;
            frameDone     <= 1'b0;
            pending       <= 16'h0;
            pending_full  <= 1'b0;
            active        <= 16'h0;
            active_loaded <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PRESC_W'(1);
            if (tick) begin
                digit_idx <= digit_idx + 2'd1;
            end
            frameDone <= boundary;
            if (accept) begin
                pending      <= displayValue;
                pending_full <= 1'b1;
            end else if (transfer) begin
                pending_full <= 1'b0;
            end
            if (transfer) begin
                active        <= pending;
                active_loaded <= 1'b1;
            end
        end
    end

    always_comb begin
        case (nibble)
            4'h0:    digit_seg = 7'b1000000;
            4'h1:    digit_seg = 7'b1111001;
            4'h2:    digit_seg = 7'b0100100;
            4'h3:    digit_seg = 7'b0110000;
            4'h4:    digit_seg = 7'b0011001;
            4'h5:    digit_seg = 7'b0010010;
            4'h6:    digit_seg = 7'b0000010;
            4'h7:    digit_seg = 7'b1111000;
            4'h8:    digit_seg = 7'b0000000;
            4'h9:    digit_seg = 7'b0010000;
            4'hA:    digit_seg = 7'b0001000;
            4'hB:    digit_seg = 7'b0000011;
            4'hC:    digit_seg = 7'b1000110;
            4'hD:    digit_seg = 7'b0100001;
            4'hE:    digit_seg = 7'b0000110;
            default: digit_seg = 7'b0001110;
        endcase
    end

    // A digit is a leading zero when it and every more significant nibble are zero
    always_comb begin
        digit_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (digit_idx)
            2'd1:    digit_blank = (active[15:4] == 12'h0);
            2'd2:    digit_blank = (active[15:8] == 8'h0);
            2'd3:    digit_blank = (active[15:12] == 4'h0);
            default: digit_blank = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_OFF;
        end else begin
            state <= state_next;
        end
    end

    // Scan only starts on a frame boundary so the first lit digit is always digit 0
    always_comb begin
        state_next    = state;
        switch_next   = 4'hF;
        segments_next = 7'h7F;
        case (state)
            ST_OFF: begin
                if (boundary && displayOn && (active_loaded || transfer)) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!displayOn) begin
                    state_next = ST_OFF;
                end else if (!digit_blank) begin
                    switch_next   = ~(4'b0001 << digit_idx);
                    segments_next = digit_seg;
                end
            end
            default: state_next = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            switchEnable <= 4'hF;
            segments     <= 7'h7F;
        end else begin
            switchEnable <= switch_next;
            segments     <= segments_next;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Scoreboard bench for seven_segment_scan_controller with REFRESH_DIV=4 (16-cycle frames).
module tb_seven_segment_scan_controller;

    localparam int unsigned REFRESH_DIV = 4;
    localparam int          FRAME       = 16;

    typedef struct packed {
        logic        blank;
        logic [15:0] val;
    } frame_t;

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic        displayOn    = 1'b0;
    logic        updateValid  = 1'b0;
    logic [15:0] displayValue = 16'h0;
    logic        updateReady;
    logic [3:0]  switchEnable;
    logic [6:0]  segments;
    logic        frameDone;

    int     n_checks = 0;
    int     n_fails  = 0;
    int     k        = 0;
    logic   mon_en   = 1'b0;
    frame_t exp_q[$];

    seven_segment_scan_controller #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .displayOn    (displayOn),
        .updateValid  (updateValid),
        .updateReady  (updateReady),
        .displayValue (displayValue),
        .switchEnable (switchEnable),
        .segments     (segments),
        .frameDone    (frameDone)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Expected {switchEnable, segments} while digit d of value v is lit
    function automatic logic [10:0] digit_exp(input logic [15:0] v, input int d);
        logic [15:0] sh;
        sh = v >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && sh == 16'h0) return {4'hF, 7'h7F};
`endif
        return {~(4'b0001 << d), seg_of(sh[3:0])};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < FRAME && (k % FRAME) != p; i++) step();
    endtask

    task automatic send(input logic [15:0] v);
        updateValid  = 1'b1;
        displayValue = v;
        step();
        updateValid  = 1'b0;
    endtask

    // Waits for n frameDone pulses, then one more cycle so the frame's last sample is consumed
    task automatic wait_frames(input int n);
        int cnt;
        for (int f = 0; f < n; f++) begin
            cnt = 0;
            do begin
                step();
                cnt++;
            end while (frameDone !== 1'b1 && cnt < 40);
            n_checks++;
            if (frameDone !== 1'b1) begin
                n_fails++;
                $display("FAIL frame_wait: frameDone=%b after %0d cycles, required 1", frameDone, cnt);
            end
        end
        step();
    endtask

    // Pops one expected frame per frameDone and checks every displayed sample of that frame
    task automatic scoreboard_monitor();
        frame_t      cur;
        logic        have_cur;
        int          pos;
        int          d;
        logic [10:0] exp;
        have_cur = 1'b0;
        pos      = 0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                have_cur = 1'b0;
                pos      = 0;
            end else if (frameDone === 1'b1) begin
                if (have_cur) begin
                    n_checks++;
                    if (pos != FRAME - 1) begin
                        n_fails++;
                        $display("FAIL sb_frame_period: frameDone after %0d samples, required %0d", pos + 1, FRAME);
                    end
                    exp = cur.blank ? 11'h7FF : digit_exp(cur.val, 3);
                    n_checks++;
                    if ({switchEnable, segments} !== exp) begin
                        n_fails++;
                        $display("FAIL sb_digit3 val=%h: got %b/%b, required %b/%b",
                                 cur.val, switchEnable, segments, exp[10:7], exp[6:0]);
                    end
                end
                if (exp_q.size() > 0) begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                end
                pos = 0;
            end else if (have_cur) begin
                pos++;
                if (pos >= FRAME) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL sb_frame_period: no frameDone after %0d samples, required %0d", pos, FRAME);
                    have_cur = 1'b0;
                    pos      = 0;
                end else begin
                    d   = (pos - 1) / 4;
                    exp = cur.blank ? 11'h7FF : digit_exp(cur.val, d);
                    n_checks++;
                    if ({switchEnable, segments} !== exp) begin
                        n_fails++;
                        $display("FAIL sb_digit%0d val=%h pos=%0d: got %b/%b, required %b/%b",
                                 d, cur.val, pos, switchEnable, segments, exp[10:7], exp[6:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_checks += 4;
        if (switchEnable !== 4'hF) begin n_fails++; $display("FAIL reset_switchEnable: got %h, required f", switchEnable); end
        if (segments !== 7'h7F) begin n_fails++; $display("FAIL reset_segments: got %h, required 7f", segments); end
        if (frameDone !== 1'b0) begin n_fails++; $display("FAIL reset_frameDone: got %b, required 0", frameDone); end
        if (updateReady !== 1'b0) begin n_fails++; $display("FAIL reset_updateReady: got %b, required 0", updateReady); end
        reset = 1'b0;
        k     = 0;
        #1;
        n_checks++;
        if (updateReady !== 1'b1) begin n_fails++; $display("FAIL release_updateReady: got %b, required 1", updateReady); end
    endtask

    task automatic test_idle();
        logic fd_exp;
        displayOn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            fd_exp = ((k % FRAME) == 0) ? 1'b1 : 1'b0;
            n_checks += 3;
            if ({switchEnable, segments} !== 11'h7FF) begin
                n_fails++;
                $display("FAIL idle_blank k=%0d: got %b/%b, required 1111/1111111", k, switchEnable, segments);
            end
            if (updateReady !== 1'b1) begin n_fails++; $display("FAIL idle_updateReady k=%0d: got %b, required 1", k, updateReady); end
            if (frameDone !== fd_exp) begin n_fails++; $display("FAIL idle_frameDone k=%0d: got %b, required %b", k, frameDone, fd_exp); end
        end
    endtask

    task automatic test_basic();
        mon_en = 1'b1;
        wait_phase(4);
        exp_q.push_back('{blank: 1'b0, val: 16'h1234});
        send(16'h1234);
        n_checks++;
        if (updateReady !== 1'b0) begin n_fails++; $display("FAIL basic_ready_after_accept: got %b, required 0", updateReady); end
        wait_frames(2);
    endtask

    task automatic test_update_mid_frame();
        int cnt;
        wait_phase(6);
        exp_q.push_back('{blank: 1'b0, val: 16'hABCD});
        send(16'hABCD);
        for (cnt = 0; cnt < 40 && frameDone !== 1'b1; cnt++) begin
            n_checks++;
            if (updateReady !== 1'b0) begin n_fails++; $display("FAIL mid_ready_pending k=%0d: got %b, required 0", k, updateReady); end
            step();
        end
        n_checks++;
        if (frameDone !== 1'b1 || updateReady !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_ready_at_boundary: frameDone=%b updateReady=%b, required 1/1", frameDone, updateReady);
        end
        wait_frames(1);
    endtask

    task automatic test_hold_valid();
        int cnt;
        wait_phase(4);
        exp_q.push_back('{blank: 1'b0, val: 16'h9876});
        exp_q.push_back('{blank: 1'b0, val: 16'h5555});
        updateValid  = 1'b1;
        displayValue = 16'h9876;
        step();
        displayValue = 16'h5555;
        for (cnt = 0; cnt < 40 && frameDone !== 1'b1; cnt++) begin
            n_checks++;
            if (updateReady !== 1'b0) begin n_fails++; $display("FAIL hold_ready_pending k=%0d: got %b, required 0", k, updateReady); end
            step();
        end
        n_checks++;
        if (frameDone !== 1'b1 || updateReady !== 1'b1) begin
            n_fails++;
            $display("FAIL hold_ready_at_boundary: frameDone=%b updateReady=%b, required 1/1", frameDone, updateReady);
        end
        step();
        updateValid = 1'b0;
        n_checks++;
        if (updateReady !== 1'b0) begin n_fails++; $display("FAIL hold_accepted_after_boundary: updateReady=%b, required 0", updateReady); end
        wait_frames(2);
    endtask

    task automatic test_boundary_accept();
        int cnt;
        wait_phase(15);
        exp_q.push_back('{blank: 1'b0, val: 16'h5555});
        exp_q.push_back('{blank: 1'b0, val: 16'h0F3E});
        send(16'h0F3E);
        n_checks++;
        if (frameDone !== 1'b1 || updateReady !== 1'b0) begin
            n_fails++;
            $display("FAIL bnd_accept_pending: frameDone=%b updateReady=%b, required 1/0", frameDone, updateReady);
        end
        step();
        for (cnt = 0; cnt < 40 && frameDone !== 1'b1; cnt++) begin
            n_checks++;
            if (updateReady !== 1'b0) begin n_fails++; $display("FAIL bnd_ready_pending k=%0d: got %b, required 0", k, updateReady); end
            step();
        end
        n_checks++;
        if (updateReady !== 1'b1) begin n_fails++; $display("FAIL bnd_ready_after_transfer: got %b, required 1", updateReady); end
        wait_frames(1);
    endtask

    task automatic test_display_off();
        int          cnt;
        logic [10:0] exp;
        mon_en = 1'b0;
        wait_phase(6);
        displayOn = 1'b0;
        for (int i = 0; i < 21; i++) begin
            step();
            n_checks++;
            if ({switchEnable, segments} !== 11'h7FF) begin
                n_fails++;
                $display("FAIL off_blank k=%0d: got %b/%b, required 1111/1111111", k, switchEnable, segments);
            end
        end
        displayOn = 1'b1;
        exp_q.push_back('{blank: 1'b0, val: 16'h0F3E});
        mon_en = 1'b1;
        cnt = 0;
        do begin
            step();
            cnt++;
            n_checks++;
            if ({switchEnable, segments} !== 11'h7FF) begin
                n_fails++;
                $display("FAIL resume_early k=%0d: got %b/%b, required 1111/1111111", k, switchEnable, segments);
            end
        end while (frameDone !== 1'b1 && cnt < 40);
        exp = digit_exp(16'h0F3E, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({switchEnable, segments} !== exp) begin
                n_fails++;
                $display("FAIL resume_digit0 k=%0d: got %b/%b, required %b/%b", k, switchEnable, segments, exp[10:7], exp[6:0]);
            end
        end
        wait_frames(1);
    endtask

    task automatic test_reset_mid_scan();
        mon_en = 1'b0;
        wait_phase(2);
        send(16'h4242);
        #2;
        reset = 1'b1;
        #1;
        n_checks += 3;
        if ({switchEnable, segments} !== 11'h7FF) begin
            n_fails++;
            $display("FAIL async_reset_blank: got %b/%b, required 1111/1111111", switchEnable, segments);
        end
        if (frameDone !== 1'b0) begin n_fails++; $display("FAIL async_reset_frameDone: got %b, required 0", frameDone); end
        if (updateReady !== 1'b0) begin n_fails++; $display("FAIL async_reset_ready: got %b, required 0", updateReady); end
        repeat (2) step();
        reset = 1'b0;
        k     = 0;
        #1;
        n_checks++;
        if (updateReady !== 1'b1) begin n_fails++; $display("FAIL rereset_ready: got %b, required 1", updateReady); end
        exp_q.push_back('{blank: 1'b1, val: 16'h0});
        mon_en = 1'b1;
        wait_frames(2);
    endtask

    task automatic test_leading_zero();
        int          cnt;
        int          d;
        logic [10:0] exp;
        wait_phase(4);
        exp_q.push_back('{blank: 1'b0, val: 16'h0007});
        send(16'h0007);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (frameDone !== 1'b1 && cnt < 40);
        for (int p = 1; p <= FRAME; p++) begin
            step();
            d = (p - 1) / 4;
            if (d == 0) begin
                exp = {4'b1110, 7'b1111000};
            end else begin
`ifdef LEADING_ZERO_BLANK_EN
                exp = {4'hF, 7'h7F};
`else
                exp = {~(4'b0001 << d), 7'b1000000};
`endif
            end
            n_checks++;
            if ({switchEnable, segments} !== exp) begin
                n_fails++;
                $display("FAIL lzb_digit%0d p=%0d: got %b/%b, required %b/%b", d, p, switchEnable, segments, exp[10:7], exp[6:0]);
            end
        end
        step();
    endtask

    initial begin
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_idle();
        test_basic();
        test_update_mid_frame();
        test_hold_valid();
        test_boundary_accept();
        test_display_off();
        test_reset_mid_scan();
        test_leading_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
